// File: rtl/fp_multiplier_param.sv
// Iterative IEEE 754 multiplier with parameterised exponent/fraction widths and radix.
// Special operands finish in one cycle; others go through MUL -> NORM -> ROUND with RNE.
module fp_multiplier_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BPC   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   rs1,
    input  logic [EXP_W+MAN_W:0]   rs2,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   valid,
    output logic                   busy,
    output logic [3:0]             flags
);
    localparam int W      = EXP_W + MAN_W + 1;
    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int ITER   = (SIG_W + BPC - 1) / BPC;
    localparam int CNT_W  = $clog2(ITER + 1);
    localparam int EW     = EXP_W + 2;
    localparam int BIAS   = 2 ** (EXP_W - 1) - 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);
    localparam logic [EW-1:0]    BIAS_V   = EW'(BIAS);
    localparam logic [EW-1:0]    EXP_MAX  = {2'b00, {EXP_W{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_ROUND} state_t;

    state_t              state_q, state_d;
    logic                sign_q, sign_d;
    logic [EW-1:0]       exp_q, exp_d;
    logic [PROD_W-1:0]   mcand_q, mcand_d;
    logic [SIG_W-1:0]    mplier_q, mplier_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MAN_W-1:0]    frac_q, frac_d;
    logic                guard_q, guard_d;
    logic                sticky_q, sticky_d;
    logic [W-1:0]        result_q, result_d;
    logic [3:0]          flags_q, flags_d;
    logic                valid_q, valid_d;

    // Operand classification
    logic [EXP_W-1:0] e1, e2;
    logic [MAN_W-1:0] f1, f2;
    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, special;
    logic res_sign;
    logic [EW-1:0] exp_sum;

    assign e1       = rs1[W-2:MAN_W];
    assign e2       = rs2[W-2:MAN_W];
    assign f1       = rs1[MAN_W-1:0];
    assign f2       = rs2[MAN_W-1:0];
    assign a_zero   = (e1 == '0);
    assign b_zero   = (e2 == '0);
    assign a_inf    = (&e1) && (f1 == '0);
    assign b_inf    = (&e2) && (f2 == '0);
    assign a_nan    = (&e1) && (f1 != '0);
    assign b_nan    = (&e2) && (f2 != '0);
    assign special  = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
    assign res_sign = rs1[W-1] ^ rs2[W-1];
    assign exp_sum  = {2'b00, e1} + {2'b00, e2} - BIAS_V;

    // Radix-2^BPC step: chain of conditional partial-product adds onto the accumulator
    logic [PROD_W-1:0] pp_chain [BPC+1];
    assign pp_chain[0] = acc_q;
    generate
        for (genvar gi = 0; gi < BPC; gi++) begin : g_pp
            assign pp_chain[gi+1] = pp_chain[gi] + (mplier_q[gi] ? (mcand_q << gi) : '0);
        end
    endgenerate

    // Normalisation of the raw product in [1,4)
    logic              prod_hi;
    logic [MAN_W-1:0]  norm_frac;
    logic              norm_guard, norm_sticky;

    assign prod_hi     = acc_q[PROD_W-1];
    assign norm_frac   = prod_hi ? acc_q[PROD_W-2:MAN_W+1] : acc_q[PROD_W-3:MAN_W];
    assign norm_guard  = prod_hi ? acc_q[MAN_W] : acc_q[MAN_W-1];
    assign norm_sticky = prod_hi ? (|acc_q[MAN_W-1:0]) : (|acc_q[MAN_W-2:0]);

    // Round to nearest even and range check
    logic              round_inc, round_carry, inexact, ovf, unf;
    logic [MAN_W-1:0]  frac_r;
    logic [EW-1:0]     exp_r;

    assign round_inc              = guard_q & (sticky_q | frac_q[0]);
    assign {round_carry, frac_r}  = {1'b0, frac_q} + {{MAN_W{1'b0}}, round_inc};
    assign exp_r                  = exp_q + {{(EW-1){1'b0}}, round_carry};
    assign inexact                = guard_q | sticky_q;
    assign ovf                    = $signed(exp_r) >= $signed(EXP_MAX);
    assign unf                    = exp_r[EW-1] | (exp_r == '0);

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        frac_d   = frac_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        result_d = result_q;
        flags_d  = flags_q;
        valid_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sign_d = res_sign;
                    if (special) begin
                        valid_d = 1'b1;
                        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
                            result_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                            flags_d  = 4'b1000;
                        end else if (a_inf || b_inf) begin
                            result_d = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                            flags_d  = 4'b0000;
                        end else begin
                            result_d = {res_sign, {(W-1){1'b0}}};
                            flags_d  = 4'b0000;
                        end
                    end else begin
                        exp_d    = exp_sum;
                        mcand_d  = {{SIG_W{1'b0}}, 1'b1, f1};
                        mplier_d = {1'b1, f2};
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end
                end
            end
            S_MUL: begin
                acc_d    = pp_chain[BPC];
                mplier_d = mplier_q >> BPC;
                mcand_d  = mcand_q << BPC;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                exp_d    = exp_q + {{(EW-1){1'b0}}, prod_hi};
                frac_d   = norm_frac;
                guard_d  = norm_guard;
                sticky_d = norm_sticky;
                state_d  = S_ROUND;
            end
            S_ROUND: begin
                valid_d = 1'b1;
                state_d = S_IDLE;
                if (ovf) begin
                    result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags_d  = 4'b0101;
                end else if (unf) begin
                    result_d = {sign_q, {(W-1){1'b0}}};
                    flags_d  = 4'b0011;
                end else begin
                    result_d = {sign_q, exp_r[EXP_W-1:0], frac_r};
                    flags_d  = {3'b000, inexact};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            frac_q   <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            frac_q   <= frac_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            valid_q  <= valid_d;
        end
    end

    assign result = result_q;
    assign flags  = flags_q;
    assign valid  = valid_q;
    assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_multiplier_param.sv
// Directed bench for fp_multiplier_param: default single-precision instance plus a
// half-precision-style instance (EXP_W=5, MAN_W=10, BPC=4).
module tb_fp_multiplier_param;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, valid, busy;
    logic [31:0] rs1, rs2, result;
    logic [3:0]  flags;

    logic        s_start, s_valid, s_busy;
    logic [15:0] s_rs1, s_rs2, s_result;
    logic [3:0]  s_flags;

    int n_vec = 0;
    int n_err = 0;

    fp_multiplier_param dut (
        .clk(clk), .rst(rst), .start(start), .rs1(rs1), .rs2(rs2),
        .result(result), .valid(valid), .busy(busy), .flags(flags)
    );

    fp_multiplier_param #(.EXP_W(5), .MAN_W(10), .BPC(4)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .rs1(s_rs1), .rs2(s_rs2),
        .result(s_result), .valid(s_valid), .busy(s_busy), .flags(s_flags)
    );

    // Drive one request and wait (bounded) for valid; lat counts edges after acceptance.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [3:0] f,
                         output int lat, output int bcnt);
        @(negedge clk);
        rs1 = a; rs2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; bcnt = 0;
        while (!valid && lat < 40) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        r = result; f = flags;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rs1 = '0; rs2 = '0;
        s_start = 1'b0; s_rs1 = '0; s_rs2 = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({result, flags, valid, busy} !== 38'd0) begin
            n_err++;
            $display("FAIL reset_main: got result=%h flags=%b valid=%b busy=%b, want all 0", result, flags, valid, busy);
        end
        n_vec++;
        if ({s_result, s_flags, s_valid, s_busy} !== 22'd0) begin
            n_err++;
            $display("FAIL reset_small: got result=%h flags=%b valid=%b busy=%b, want all 0", s_result, s_flags, s_valid, s_busy);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] r; logic [3:0] f; int lat, bc;
        do_op(32'h3FC00000, 32'h40000000, r, f, lat, bc);
        $display("basic 3FC00000*40000000 -> %h flags=%b lat=%0d busy=%0d", r, f, lat, bc);
        n_vec++;
        if (r !== 32'h40400000 || f !== 4'b0000) begin
            n_err++;
            $display("FAIL basic_result: got %h/%b, want 40400000/0000", r, f);
        end
        n_vec++;
        if (lat != 10 || bc != 10) begin
            n_err++;
            $display("FAIL basic_timing: got lat=%0d busy_cycles=%0d, want 10/10", lat, bc);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_busy_on_valid: got busy=%b, want 0", busy);
        end
        @(posedge clk); #1;
        n_vec++;
        if (valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_pulse: got valid=%b one cycle later, want 0", valid);
        end
    endtask

    task automatic test_rounding();
        logic [31:0] a [3], b [3], er [3];
        logic [31:0] r; logic [3:0] f; int lat, bc;
        a[0] = 32'h3F800001; b[0] = 32'h3F800001; er[0] = 32'h3F800002; // sticky only
        a[1] = 32'h3FC00000; b[1] = 32'h3F800003; er[1] = 32'h3FC00004; // tie, even LSB
        a[2] = 32'h3FC00000; b[2] = 32'h3F800001; er[2] = 32'h3FC00002; // tie, odd LSB
        for (int i = 0; i < 3; i++) begin
            do_op(a[i], b[i], r, f, lat, bc);
            $display("round %h*%h -> %h flags=%b lat=%0d", a[i], b[i], r, f, lat);
            n_vec++;
            if (r !== er[i] || f !== 4'b0001 || lat != 10) begin
                n_err++;
                $display("FAIL round_%0d: got %h/%b lat=%0d, want %h/0001 lat=10", i, r, f, lat, er[i]);
            end
        end
    endtask

    task automatic test_range();
        logic [31:0] r; logic [3:0] f; int lat, bc;
        do_op(32'h7F000000, 32'h40000000, r, f, lat, bc);
        $display("overflow 7F000000*40000000 -> %h flags=%b lat=%0d", r, f, lat);
        n_vec++;
        if (r !== 32'h7F800000 || f !== 4'b0101 || lat != 10) begin
            n_err++;
            $display("FAIL overflow: got %h/%b lat=%0d, want 7F800000/0101 lat=10", r, f, lat);
        end
        do_op(32'h00800000, 32'h3F000000, r, f, lat, bc);
        $display("underflow 00800000*3F000000 -> %h flags=%b lat=%0d", r, f, lat);
        n_vec++;
        if (r !== 32'h00000000 || f !== 4'b0011 || lat != 10) begin
            n_err++;
            $display("FAIL underflow: got %h/%b lat=%0d, want 00000000/0011 lat=10", r, f, lat);
        end
    endtask

    task automatic test_special();
        logic [31:0] a [4], b [4], er [4];
        logic [3:0]  ef [4];
        logic [31:0] r; logic [3:0] f; int lat, bc;
        a[0] = 32'h7F800000; b[0] = 32'h80000000; er[0] = 32'h7FC00000; ef[0] = 4'b1000;
        a[1] = 32'hFF800000; b[1] = 32'h40000000; er[1] = 32'hFF800000; ef[1] = 4'b0000;
        a[2] = 32'hFFC12345; b[2] = 32'h3F800000; er[2] = 32'h7FC00000; ef[2] = 4'b1000;
        a[3] = 32'h80000000; b[3] = 32'h40400000; er[3] = 32'h80000000; ef[3] = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            do_op(a[i], b[i], r, f, lat, bc);
            $display("special %h*%h -> %h flags=%b lat=%0d busy=%0d", a[i], b[i], r, f, lat, bc);
            n_vec++;
            if (r !== er[i] || f !== ef[i] || lat != 0 || bc != 0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL special_%0d: got %h/%b lat=%0d busy_cycles=%0d, want %h/%b lat=0 busy_cycles=0",
                         i, r, f, lat, bc, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat, extra;
        @(negedge clk);
        rs1 = 32'h3FC00000; rs2 = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rs1 = 32'h7F800000; rs2 = 32'h00000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 3;
        while (!valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("ignore_start -> %h flags=%b lat=%0d", result, flags, lat);
        n_vec++;
        if (result !== 32'h40400000 || flags !== 4'b0000 || lat != 10) begin
            n_err++;
            $display("FAIL ignore_start: got %h/%b lat=%0d, want 40400000/0000 lat=10", result, flags, lat);
        end
        extra = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (valid) extra++;
        end
        n_vec++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL ignore_start_extra_valid: got %0d extra valid cycles, want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; logic [3:0] f; int lat, bc;
        do_op(32'h40000000, 32'h40400000, r, f, lat, bc);
        n_vec++;
        if (r !== 32'h40C00000 || lat != 10) begin
            n_err++;
            $display("FAIL b2b_first: got %h lat=%0d, want 40C00000 lat=10", r, lat);
        end
        rs1 = 32'h3FC00000; rs2 = 32'hC0000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        n_vec++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_accept: got valid=%b busy=%b after re-accept, want 0/1", valid, busy);
        end
        while (!valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("b2b second 3FC00000*C0000000 -> %h flags=%b lat=%0d", result, flags, lat);
        n_vec++;
        if (result !== 32'hC0400000 || flags !== 4'b0000 || lat != 10) begin
            n_err++;
            $display("FAIL b2b_second: got %h/%b lat=%0d, want C0400000/0000 lat=10", result, flags, lat);
        end
    endtask

    task automatic test_reset_mid();
        int vcnt;
        @(negedge clk);
        rs1 = 32'h3FC00000; rs2 = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        $display("reset_mid -> result=%h flags=%b valid=%b busy=%b", result, flags, valid, busy);
        n_vec++;
        if (result !== 32'h0 || flags !== 4'b0 || valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got %h/%b valid=%b busy=%b, want 0/0 0 0", result, flags, valid, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        vcnt = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (valid) vcnt++;
        end
        n_vec++;
        if (vcnt != 0 || result !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid_after: got %0d valid cycles result=%h, want 0 and 0", vcnt, result);
        end
    endtask

    task automatic test_small();
        logic [15:0] a [3], b [3], er [3];
        logic [3:0]  ef [3];
        int          el [3];
        int lat;
        a[0] = 16'h3E00; b[0] = 16'h4000; er[0] = 16'h4200; ef[0] = 4'b0000; el[0] = 5;
        a[1] = 16'h7C00; b[1] = 16'h0000; er[1] = 16'h7E00; ef[1] = 4'b1000; el[1] = 0;
        a[2] = 16'h7800; b[2] = 16'h4000; er[2] = 16'h7C00; ef[2] = 4'b0101; el[2] = 5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_rs1 = a[i]; s_rs2 = b[i]; s_start = 1'b1;
            @(posedge clk); #1;
            s_start = 1'b0;
            lat = 0;
            while (!s_valid && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            $display("small %h*%h -> %h flags=%b lat=%0d", a[i], b[i], s_result, s_flags, lat);
            n_vec++;
            if (s_result !== er[i] || s_flags !== ef[i] || lat != el[i]) begin
                n_err++;
                $display("FAIL small_%0d: got %h/%b lat=%0d, want %h/%b lat=%0d",
                         i, s_result, s_flags, lat, er[i], ef[i], el[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_range();
        test_special();
        test_ignore_start();
        test_back_to_back();
        test_small();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fp_multiplier_param.md
# fp_multiplier_param

Parametrised iterative IEEE 754 floating-point multiplier for the arithmetic unit. It is the next generation of the single-precision multiplier, generalised in exponent and mantissa width and in multiplier bits retired per cycle. Over the earlier block it adds:
- round-to-nearest-even;
- full special-case handling (NaN, infinity, zero);
- overflow/underflow saturation and exception flags;
- a single-cycle fast path for special operands.

## Interface
- `EXP_W`, default 8: exponent field width.
- `MAN_W`, default 23: stored fraction width; the significand is `MAN_W+1` bits with the hidden 1.
- `BPC`, default 3: multiplier bits consumed per iteration cycle. `ITER = ceil((MAN_W+1)/BPC)`.
- `BIAS`, derived: `2^(EXP_W-1)-1`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: request; accepted on a rising edge where `start=1` and `busy=0`.
- `rs1` in `EXP_W+MAN_W+1`: operand A as {sign, exp, frac}.
- `rs2` in `EXP_W+MAN_W+1`: operand B.
- `result` out `EXP_W+MAN_W+1`: product; registered and held until the next acceptance.
- `valid` out 1: one-cycle pulse when `result` and `flags` update.
- `busy` out 1: high from the cycle after acceptance until `valid` asserts.
- `flags` out 4: {invalid, overflow, underflow, inexact}; registered with `result`.

## Operation
- **States:** IDLE, MUL, NORM, ROUND. DONE is implicit (`valid` pulse while returning to IDLE).
- **Acceptance:** `start` is sampled directly, not re-registered.
  - The accepting edge latches the operands, the sign (XOR of input signs) and the exponent sum `E = e1+e2-BIAS`. `E` is held in `EXP_W+2` bits, signed.
  - `start` while `busy=1` is ignored entirely; no queuing.
- **Operand classes:**
  - exp = 0: zero. Subnormals are flushed to zero and the sign is kept.
  - exp all ones, frac = 0: infinity.
  - exp all ones, frac ≠ 0: NaN.
- **Special fast path:** if either operand is NaN/infinity/zero, the accepting edge goes straight to the result. `valid=1` and `busy` stays 0.
  - Any NaN operand, or infinity × zero: canonical qNaN (sign 0, exp all ones, frac MSB 1, rest 0), invalid=1.
  - Infinity × finite non-zero, or infinity × infinity: signed infinity, flags 0.
  - Zero × finite: signed zero, flags 0.
- **MUL:** `ITER` cycles. Each cycle adds up to `BPC` shifted partial products of the `MAN_W+1`-bit multiplicand into a `2*(MAN_W+1)`-bit accumulator, then shifts the multiplier right by `BPC`. Zero-padded tail bits contribute nothing.
- **NORM:** the product lies in [1,4). If its MSB is set, shift right by 1 and increment `E`.
  - Guard = first dropped bit.
  - Sticky = OR of all lower dropped bits.
- **ROUND:** round to nearest even. Increment when guard & (sticky | LSB).
  - A fraction carry-out increments `E` and zeroes the fraction.
  - inexact = guard | sticky.
- **Range checks after rounding:**
  - `E >= 2^EXP_W-1`: signed infinity; overflow=1, inexact=1.
  - `E <= 0`: signed zero; underflow=1, inexact=1.
- **Output:** `result`/`flags` are written on the ROUND→IDLE edge. `valid=1` and `busy=0` for one cycle.
- **Back-to-back:** `start` is accepted in the same cycle `valid` is high, because `busy=0` then.

## Timing
- **Reset values:** `result=0`, `flags=0`, `valid=0`, `busy=0`, state IDLE, all internal registers 0.
- **Reset mid-operation:** aborts immediately. No `valid` is produced and `result` reads 0.
- **Normal path:** call the accepting edge edge 0.
  - Edges 1..`ITER`: MUL.
  - Edge `ITER+1`: NORM.
  - Edge `ITER+2`: ROUND; `valid` rises.
  - Default latency: 10 edges.
- **Special path:** `valid` rises at edge 0 itself, i.e. the cycle after `start` was sampled.
- **Pulse widths:** `valid` is never high for two consecutive cycles from the same operation.
- **`busy` high time:** exactly `ITER+2` cycles on the normal path; 0 on the special path.

## Test plan
- **Basic product (defaults):** `rs1=0x3FC00000` (1.5), `rs2=0x40000000` (2.0), start → `result=0x40400000`, `flags=0`, `valid` at edge 10, `busy` high for 10 cycles.
- **Rounding:** `0x3F800001 × 0x3F800001` → `0x3F800002`, `flags=0001`. Also check a tie case with an even LSB: no increment.
- **Overflow:** `0x7F000000 × 0x40000000` → `0x7F800000`, `flags=0101`.
- **Underflow:** `0x00800000 × 0x3F000000` → `0x00000000`, `flags=0011`.
- **Special path:**
  - `0x7F800000 × 0x80000000` → `0x7FC00000`, `flags=1000`, `valid` at edge 0, `busy` never high.
  - `0xFF800000 × 0x40000000` → `0xFF800000`.
- **Control and parametrisation:**
  - Pulse `start` mid-MUL: ignored.
  - Back-to-back: re-accept on the `valid` cycle.
  - Assert `rst` at edge 5: outputs 0, no `valid`.
  - Rerun with `EXP_W=5`, `MAN_W=10`, `BPC=4` (`ITER=3`): `0x3E00 × 0x4000` → `0x4200`, `valid` at edge 5.
